// File: rtl/dlx_mem_pkg.sv
// Shared types and helpers for the DLX data-memory path.
// Lane 0 is the most significant byte of a word (big-endian).
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } dmem_state_t;

    function automatic mem_size_t decode_size(
        input logic byte_sel,
        input logic half_sel
    );
        mem_size_t sz;
        sz = SZ_WORD;
        if (byte_sel) begin
            sz = SZ_BYTE;
        end else if (half_sel) begin
            sz = SZ_HALF;
        end
        return sz;
    endfunction

    // Bit i of the result enables byte lane i.
    function automatic logic [3:0] lane_mask(
        input mem_size_t size,
        input logic [1:0] offset
    );
        logic [3:0] m;
        unique case (size)
            SZ_BYTE: m = 4'b0001 << offset;
            SZ_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_aligned(
        input mem_size_t size,
        input logic [1:0] offset
    );
        logic ok;
        unique case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            default: ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

    // Spread right-justified store data over every lane it may land in.
    function automatic logic [31:0] replicate_store(
        input mem_size_t size,
        input logic [31:0] data
    );
        logic [31:0] w;
        unique case (size)
            SZ_BYTE: w = {4{data[7:0]}};
            SZ_HALF: w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] format_load(
        input logic [31:0] word,
        input mem_size_t size,
        input logic [1:0] offset,
        input logic sign
    );
        logic [7:0] b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (offset)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            default: b = word[7:0];
        endcase
        h = offset[1] ? word[15:0] : word[31:16];
        unique case (size)
            SZ_BYTE: r = {{24{sign & b[7]}}, b};
            SZ_HALF: r = {{16{sign & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of data memory: synchronous write, registered read.
// Reads return the contents from before a same-edge write.
module dmem_lane_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// DMEM responder: sized big-endian loads/stores with wait states,
// a combinational pipeline stall and a sticky misalignment flag.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [0:31] addr_from_proc,
    input  logic        write_enable_from_proc,
    input  logic        byte_from_proc,
    input  logic        half_word_from_proc,
    input  logic        sign_extend_from_proc,
    input  logic [0:31] data_from_proc,
    output logic [0:31] data_to_proc,
    output logic        stall,
    output logic        misaligned
);

    import dlx_mem_pkg::*;

    logic [31:0] addr;
    logic [31:0] din;
    assign addr = addr_from_proc;
    assign din  = data_from_proc;

    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    mem_size_t size_in;
    assign size_in = decode_size(byte_from_proc,
                                 half_word_from_proc);

    dmem_state_t state_q, state_d;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            off_q;
    mem_size_t             size_q;
    logic                  sign_q;
    logic                  we_q;
    logic                  bad_q;
    logic [3:0]            mask_q;
    logic [31:0]           wdata_q;
    logic                  sticky_q;
    logic [31:0]           hold_q;
    logic                  commit;
    logic                  accept;
    logic [31:0]           rword;
    logic [31:0]           resp_data;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        commit  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    accept  = ~reset;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    commit  = ~reset;
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sticky_q <= 1'b0;
            hold_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= 4'(WAIT_STATES);
                sticky_q <= sticky_q
                          | ~is_aligned(size_in, addr[1:0]);
            end else if (state_q == ACCESS
                         && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == RESP) begin
                hold_q <= resp_data;
            end
        end
    end

    // Request capture; inputs are ignored once the access is underway.
    always_ff @(posedge clock) begin
        if (accept) begin
            idx_q   <= addr[ADDR_WIDTH+1:2];
            off_q   <= addr[1:0];
            size_q  <= size_in;
            sign_q  <= sign_extend_from_proc;
            we_q    <= write_enable_from_proc;
            bad_q   <= ~is_aligned(size_in, addr[1:0]);
            mask_q  <= lane_mask(size_in, addr[1:0]);
            wdata_q <= replicate_store(size_in, din);
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dmem_lane_ram #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clock(clock),
            .en   (commit & ~bad_q),
            .we   (we_q & mask_q[i]),
            .addr (idx_q),
            .wdata(wdata_q[31-8*i -: 8]),
            .rdata(rword[31-8*i -: 8])
        );
    end

    assign resp_data = (we_q | bad_q) ? 32'd0
                     : format_load(rword, size_q,
                                   off_q, sign_q);

    assign data_to_proc = (state_q == RESP) ? resp_data
                                            : hold_q;
    assign misaligned = sticky_q;

endmodule
